// File: rtl/shift_pkg.sv
// Shared definitions for the shift arbiter slice: shift op encodings,
// output-stage state and datapath width.
package shift_pkg;

    localparam int SHIFT_W = 32;

    localparam logic [1:0] SHIFT_SRA = 2'b00;
    localparam logic [1:0] SHIFT_SRL = 2'b01;
    localparam logic [1:0] SHIFT_SLL = 2'b10;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

    // Round-robin successor of a grant index within n requesters.
    function automatic int rr_next(input int idx, input int n);
        int nxt;
        if (idx >= n - 1) begin
            nxt = 0;
        end else begin
            nxt = idx + 1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/barrelshifter32.sv
// 32-bit shifter: aluc 00 arithmetic right, 01 logical right, 1x left.
// A shift amount of zero passes the operand through.
module barrelshifter32 (
    input  logic [31:0] a,
    input  logic [4:0]  b,
    input  logic [1:0]  aluc,
    output logic [31:0] c
);

    // Select shift direction and fill from the op code.
    always_comb begin
        c = 32'h0000_0000;
        case (aluc)
            2'b00:   c = $unsigned($signed(a) >>> b);
            2'b01:   c = a >> b;
            2'b10:   c = a << b;
            2'b11:   c = a << b;
            default: c = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/shift_arbiter_rr_picker.sv
// Combinational round-robin pick: first valid requester at or after rr_ptr,
// wrapping modulo N_REQ. Produces a one-hot grant and its index.
module rr_picker #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_valid,
    input  logic [ID_W-1:0]  rr_ptr,
    output logic [N_REQ-1:0] grant_oh,
    output logic [ID_W-1:0]  grant_idx
);

    // Scan from the pointer; only the first valid hit sets the grant.
    always_comb begin
        logic found;
        int   pos;
        grant_oh  = '0;
        grant_idx = '0;
        found     = 1'b0;
        pos       = 0;
        for (int k = 0; k < N_REQ; k++) begin
            pos = (int'(rr_ptr) + k) % N_REQ;
            if (!found && req_valid[pos]) begin
                found         = 1'b1;
                grant_oh[pos] = 1'b1;
                grant_idx     = ID_W'(pos);
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one barrelshifter32 among N_REQ requesters,
// with a single-entry result stage. Optional macro SHIFT_ARB_STATS_EN adds grant counters.
module shift_arbiter
    import shift_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [SHIFT_W*N_REQ-1:0] req_a,
    input  logic [5*N_REQ-1:0]       req_b,
    input  logic [2*N_REQ-1:0]       req_aluc,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [SHIFT_W-1:0]       resp_data,
    output logic [ID_W-1:0]          resp_id
`ifdef SHIFT_ARB_STATS_EN
    ,
    input  logic                     stats_clr,
    output logic [16*N_REQ-1:0]      grant_cnt
`endif
);

    out_state_e          state_q, state_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [SHIFT_W-1:0]  data_q, data_d;
    logic [ID_W-1:0]     id_q, id_d;

    logic [N_REQ-1:0]    grant_oh_s;
    logic [ID_W-1:0]     grant_idx_s;
    logic                accept_s;
    logic [SHIFT_W-1:0]  sh_a_s;
    logic [4:0]          sh_b_s;
    logic [1:0]          sh_aluc_s;
    logic [SHIFT_W-1:0]  sh_c_s;

    rr_picker #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_picker (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr_q),
        .grant_oh  (grant_oh_s),
        .grant_idx (grant_idx_s)
    );

    barrelshifter32 u_shifter (
        .a    (sh_a_s),
        .b    (sh_b_s),
        .aluc (sh_aluc_s),
        .c    (sh_c_s)
    );

    // Accept decision and handshake; rst_n gating keeps reset cycles handshake-free.
    always_comb begin
        accept_s  = rst_n && (|req_valid) && ((state_q == OUT_EMPTY) || resp_ready);
        req_ready = '0;
        if (accept_s) begin
            req_ready = grant_oh_s;
        end else begin
            req_ready = '0;
        end
    end

    // Shifter operands: granted slice on accept, otherwise held at zero.
    always_comb begin
        sh_a_s    = '0;
        sh_b_s    = 5'd0;
        sh_aluc_s = 2'b00;
        if (accept_s) begin
            sh_a_s    = req_a[int'(grant_idx_s)*SHIFT_W +: SHIFT_W];
            sh_b_s    = req_b[int'(grant_idx_s)*5 +: 5];
            sh_aluc_s = req_aluc[int'(grant_idx_s)*2 +: 2];
        end else begin
            sh_a_s    = '0;
            sh_b_s    = 5'd0;
            sh_aluc_s = 2'b00;
        end
    end

    // Output stage and pointer next-state; a drain without accept keeps stale data.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        data_d   = data_q;
        id_d     = id_q;
        if (accept_s) begin
            state_d  = OUT_FULL;
            data_d   = sh_c_s;
            id_d     = grant_idx_s;
            rr_ptr_d = ID_W'(rr_next(int'(grant_idx_s), N_REQ));
        end else if ((state_q == OUT_FULL) && resp_ready) begin
            state_d = OUT_EMPTY;
        end else begin
            state_d = state_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= OUT_EMPTY;
            rr_ptr_q <= '0;
            data_q   <= '0;
            id_q     <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            data_q   <= data_d;
            id_q     <= id_d;
        end
    end

    assign resp_valid = (state_q == OUT_FULL);
    assign resp_data  = data_q;
    assign resp_id    = id_q;

`ifdef SHIFT_ARB_STATS_EN
    logic [15:0] cnt_q [N_REQ];
    logic [15:0] cnt_d [N_REQ];

    // Saturating per-requester grant counts; a clear wins over a same-cycle grant.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            cnt_d[i] = cnt_q[i];
            if (stats_clr) begin
                cnt_d[i] = 16'h0000;
            end else if (accept_s && grant_oh_s[i] && (cnt_q[i] != 16'hFFFF)) begin
                cnt_d[i] = cnt_q[i] + 16'd1;
            end else begin
                cnt_d[i] = cnt_q[i];
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_REQ; i++) begin
            if (!rst_n) begin
                cnt_q[i] <= 16'h0000;
            end else begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Flatten counters onto the output bus.
    always_comb begin
        grant_cnt = '0;
        for (int i = 0; i < N_REQ; i++) begin
            grant_cnt[16*i +: 16] = cnt_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter (N_REQ=4) with hand-computed expectations.
module tb_shift_arbiter;

    localparam int N  = 4;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [32*N-1:0] req_a;
    logic [5*N-1:0]  req_b;
    logic [2*N-1:0]  req_aluc;
    logic            resp_valid;
    logic            resp_ready;
    logic [31:0]     resp_data;
    logic [IW-1:0]   resp_id;
`ifdef SHIFT_ARB_STATS_EN
    logic            stats_clr;
    logic [16*N-1:0] grant_cnt;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    shift_arbiter #(.N_REQ(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_aluc   (req_aluc),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_id    (resp_id)
`ifdef SHIFT_ARB_STATS_EN
        ,
        .stats_clr  (stats_clr),
        .grant_cnt  (grant_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [4:0] b, input logic [1:0] op);
        req_a[32*i +: 32] = a;
        req_b[5*i +: 5]   = b;
        req_aluc[2*i +: 2] = op;
    endtask

    // Advance one edge and settle past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_id;
        rst_n      = 1'b0;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        req_aluc   = '0;
        resp_ready = 1'b0;
`ifdef SHIFT_ARB_STATS_EN
        stats_clr  = 1'b0;
`endif
        // Reset: ready must stay low even with requests present.
        req_valid = 4'b1111;
        #1;
        chk("rst_ready", 64'(req_ready), 64'h0);
        tick();
        tick();
        chk("rst_valid", 64'(resp_valid), 64'h0);
        chk("rst_ready2", 64'(req_ready), 64'h0);

        req_valid = '0;
        rst_n     = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("idle_valid", 64'(resp_valid), 64'h0);
            chk("idle_ready", 64'(req_ready), 64'h0);
            chk("idle_data", 64'(resp_data), 64'h0);
        end

        // Requester 2: SRA, SRL, SLL of 0x8000_0000 by 4.
        resp_ready = 1'b1;
        req_valid  = 4'b0100;
        set_req(2, 32'h8000_0000, 5'd4, 2'b00);
        #1;
        chk("r2_ready", 64'(req_ready), 64'h4);
        tick();
        chk("sra_valid", 64'(resp_valid), 64'h1);
        chk("sra_data", 64'(resp_data), 64'hF800_0000);
        chk("sra_id", 64'(resp_id), 64'h2);
        set_req(2, 32'h8000_0000, 5'd4, 2'b01);
        tick();
        chk("srl_data", 64'(resp_data), 64'h0800_0000);
        set_req(2, 32'h8000_0000, 5'd4, 2'b10);
        tick();
        chk("sll_data", 64'(resp_data), 64'h0);
        chk("sll_id", 64'(resp_id), 64'h2);

        // Drain without accept: empty, data holds.
        req_valid = '0;
        tick();
        chk("drain_valid", 64'(resp_valid), 64'h0);
        chk("drain_data", 64'(resp_data), 64'h0);

        // All four valid, pointer now at 3: grants 3,0,1,2,3,0.
        for (int i = 0; i < N; i++) begin
            set_req(i, 32'(i + 1), 5'(i), 2'b10);
        end
        req_valid = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            exp_id = (3 + k) % N;
            #1;
            chk("rr_ready", 64'(req_ready), 64'(1 << exp_id));
            tick();
            chk("rr_valid", 64'(resp_valid), 64'h1);
            chk("rr_id", 64'(resp_id), 64'(exp_id));
            chk("rr_data", 64'(resp_data), 64'((exp_id + 1) << exp_id));
        end

        // Backpressure with requesters 1 and 3 pending; pointer at 1.
        resp_ready = 1'b0;
        req_valid  = 4'b1010;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("bp_ready", 64'(req_ready), 64'h0);
            tick();
            chk("bp_valid", 64'(resp_valid), 64'h1);
            chk("bp_data", 64'(resp_data), 64'h1);
            chk("bp_id", 64'(resp_id), 64'h0);
        end
        resp_ready = 1'b1;
        #1;
        chk("rel_ready", 64'(req_ready), 64'h2);
        tick();
        chk("rel_valid", 64'(resp_valid), 64'h1);
        chk("rel_id", 64'(resp_id), 64'h1);
        chk("rel_data", 64'(resp_data), 64'h4);

        // Reset while full with 0 and 3 pending; pointer would otherwise favour 3.
        resp_ready = 1'b0;
        req_valid  = 4'b1001;
        rst_n      = 1'b0;
        #1;
        chk("mrst_ready", 64'(req_ready), 64'h0);
        tick();
        chk("mrst_valid", 64'(resp_valid), 64'h0);
        chk("mrst_data", 64'(resp_data), 64'h0);
        chk("mrst_id", 64'(resp_id), 64'h0);
        rst_n      = 1'b1;
        resp_ready = 1'b1;
        #1;
        chk("post_rst_ready0", 64'(req_ready), 64'h1);
        tick();
        chk("post_rst_id0", 64'(resp_id), 64'h0);
        chk("post_rst_data0", 64'(resp_data), 64'h1);
        #1;
        chk("post_rst_ready3", 64'(req_ready), 64'h8);
        tick();
        chk("post_rst_id3", 64'(resp_id), 64'h3);
        chk("post_rst_data3", 64'(resp_data), 64'h20);

        // Boundary shifts: b=0 passthrough, aluc 11 left, SRA full sign fill.
        req_valid = 4'b0010;
        set_req(1, 32'h7000_0001, 5'd0, 2'b00);
        tick();
        chk("b0_pass", 64'(resp_data), 64'h7000_0001);
        set_req(1, 32'h0000_0003, 5'd31, 2'b11);
        tick();
        chk("op11_left", 64'(resp_data), 64'h8000_0000);
        req_valid = 4'b0001;
        set_req(0, 32'hF0F0_0000, 5'd31, 2'b00);
        tick();
        chk("sra31", 64'(resp_data), 64'hFFFF_FFFF);
        set_req(0, 32'h7FFF_FFFF, 5'd31, 2'b00);
        tick();
        chk("sra31_pos", 64'(resp_data), 64'h0);
        chk("sra31_id", 64'(resp_id), 64'h0);

`ifdef SHIFT_ARB_STATS_EN
        // Saturation of requester 0, then clear with a grant in the same cycle.
        for (int c = 0; c < 70000; c++) begin
            @(posedge clk);
        end
        #1;
        chk("cnt_sat", 64'(grant_cnt[15:0]), 64'hFFFF);
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        chk("cnt_clr", 64'(grant_cnt), 64'h0);
        tick();
        chk("cnt_after_clr", 64'(grant_cnt), 64'h1);
`endif

        req_valid = '0;
        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/shift_arbiter.md
# shift_arbiter

Round-robin arbiter and sequencer that shares one `barrelshifter32` instance among `N_REQ` requesters. Each requester presents a shift job through a valid/ready handshake. The block grants one job per cycle, drives the shared shifter combinationally, and registers the result into a single-entry output stage with its requester ID. It sits between the ALU-side clients and the shifter datapath, and is the only driver of the shifter's `a`/`b`/`aluc` inputs.

## Interface
- `N_REQ`, default 4: number of requesters, legal range 2..8.
- `ID_W`, default `$clog2(N_REQ)`: width of the requester ID.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: reset, synchronous and active-low.
- `req_valid`, input, `N_REQ`: job present, one bit per requester.
- `req_ready`, output, `N_REQ`: job accepted this cycle (one-hot or zero).
- `req_a`, input, `32*N_REQ`: operand per requester; slice i = bits `[32i+31:32i]`.
- `req_b`, input, `5*N_REQ`: shift amount per requester.
- `req_aluc`, input, `2*N_REQ`: shift op per requester.
  - `00` arithmetic right.
  - `01` logical right.
  - `1x` left.
- `resp_valid`, output, 1: result register holds a result.
- `resp_ready`, input, 1: consumer takes the result.
- `resp_data`, output, 32: shifted value.
- `resp_id`, output, `ID_W`: index of the requester that produced `resp_data`.

## Operation
- Output stage has two states:
  - EMPTY: `resp_valid`=0.
  - FULL: `resp_valid`=1.
- Accept condition: `accept = |req_valid && (EMPTY || resp_ready)`. This gives throughput of one job per cycle while the consumer keeps `resp_ready` high.
- Grant rule:
  - Round-robin starting at pointer `rr_ptr`: the first i in `rr_ptr, rr_ptr+1, … (mod N_REQ)` with `req_valid[i]=1`.
  - `req_ready[i]=1` only for the granted i and only when `accept`=1.
  - `req_ready` is combinational from `req_valid`, state and `resp_ready`.
- On accept:
  - Shifter inputs take the granted slice.
  - `resp_data` ← shifter output `c`; `resp_id` ← i; state → FULL.
  - `rr_ptr` ← (i+1) mod `N_REQ`.
- When not accepting:
  - Shifter inputs are driven with zero.
  - `rr_ptr` holds.
- FULL with `resp_ready`=1 and no accept: state → EMPTY; data/ID hold their stale values.
- FULL with `resp_ready`=0: data, ID and state hold; every `req_ready`=0 (backpressure).
- Requesters must hold `req_*` stable while valid and not ready. The block does not check this.
- Shift semantics are exactly those of `barrelshifter32`:
  - `b`=0 passes `a` through unchanged.
  - Arithmetic right fills with `a[31]`.
  - Logical right and left fill with 0.

## Timing
- Reset (`rst_n`=0 at a rising edge):
  - State EMPTY, `rr_ptr`=0, `resp_data`=0, `resp_id`=0.
  - `resp_valid`=0 and `req_ready`=0 while `rst_n`=0.
- Reset mid-operation discards any held result; no handshake completes in a reset cycle.
- Latency: job accepted at edge k; result visible with `resp_valid`=1 after edge k.
- Simultaneous drain and accept in one cycle: the new result replaces the old one; `resp_valid` stays 1.
- `rr_ptr` wrap: after granting `N_REQ`-1 the pointer goes to 0.

## Configuration
- Macro `SHIFT_ARB_STATS_EN`.
- Defined:
  - Adds output `grant_cnt` of width `16*N_REQ`: per-requester saturating counters (stop at 16'hFFFF).
  - A counter increments on each accept for that requester.
  - Counters clear on reset.
  - Adds input `stats_clr`: synchronous clear of all counters; a grant in the same cycle as `stats_clr` is not counted.
- Undefined: neither port exists and no counter logic is built. All other behaviour is identical.

## Structure
- Shared package `shift_pkg` holds:
  - aluc encodings `SHIFT_SRA`=2'b00, `SHIFT_SRL`=2'b01, `SHIFT_SLL`=2'b10.
  - Output state enum `{OUT_EMPTY, OUT_FULL}`.
  - Constant `SHIFT_W`=32.
- One natural sub-module: `rr_picker`, a combinational round-robin priority pick. Its interface:
  - Inputs: `req_valid` and `rr_ptr`.
  - Outputs: one-hot grant and grant index.
- `barrelshifter32` is instantiated once, unmodified.

## Test plan
- Reset release, no requests → `resp_valid`=0, `req_ready`=0, `resp_data`=0 for 5 cycles.
- Requester 2 sends `a`=32'h8000_0000, `b`=4, `aluc`=00, `resp_ready`=1:
  - Next cycle `resp_data`=32'hF800_0000, `resp_id`=2.
  - Repeat with `aluc`=01 → 32'h0800_0000.
  - Repeat with `aluc`=10 → 0.
- All 4 requesters valid continuously, `resp_ready`=1 → grants in order 0,1,2,3,0,…; one result per cycle; no requester starved.
- Backpressure: result FULL, `resp_ready`=0 for 3 cycles with requesters 1 and 3 valid:
  - `req_ready`=0 and data held throughout.
  - On release, requester 1 is granted in the same cycle as the drain.
- Reset asserted while FULL with requests pending:
  - Next cycle `resp_valid`=0, `rr_ptr`=0.
  - After release, requester 0 wins against requester 3.
- With `SHIFT_ARB_STATS_EN`:
  - 70000 grants to requester 0 → `grant_cnt[15:0]`=16'hFFFF.
  - `stats_clr` → all counters 0 on the next cycle.
